sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 74 +++++++
 tb/tb_sync_fifo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and count-decoded full/empty flags.
// Depth may be any value >= 2; pointers wrap explicitly rather than by overflow.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int CNT_W = $clog2(DATA_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DATA_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_ok;
  logic                  rd_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Acceptance uses the flags as they stood before the edge.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= next_ptr(wptr);
      end
      if (rd_ok) begin
        rptr <= next_ptr(rptr);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CNT_W'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Read port: one cycle of latency, holds between accepted reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rptr];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (8x8): reset, ordering, full/empty boundaries,
// pointer wrap, simultaneous read/write and mid-operation reset.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int tests = 0;
  int fails = 0;

  sync_fifo #(.DATA_WIDTH(8), .DATA_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; rd_en = 1'b0; data_in = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1; wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic both(input logic [7:0] d);
    wr_en = 1'b1; rd_en = 1'b1; data_in = d;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seq [10];
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_dout", data_out, 8'h00);

    rd_en = 1'b1; tick(); tick(); rd_en = 1'b0;
    check("underflow_dout", data_out, 8'h00);
    check("underflow_empty", empty, 1);

    push(8'h11);
    check("one_empty", empty, 0);
    pop();
    check("one_dout", data_out, 8'h11);
    check("one_empty_after", empty, 1);

    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      if (i == 7) check("fill7_full", full, 0);
    end
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    push(8'hFF);
    check("overflow_full", full, 1);
    check("overflow_dout", data_out, 8'h11);
    for (int i = 1; i <= 8; i++) begin
      pop();
      check($sformatf("drain_%0d", i), data_out, 32'(i));
      if (i == 1) check("drain_full_drop", full, 0);
    end
    check("drain_empty", empty, 1);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
      for (int i = 0; i < 3; i++) begin
        pop();
        check($sformatf("wrap3_%0d_%0d", r, i), data_out, 32'(8'hA0 + 8'(i)));
      end
    end
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    check("wrap8_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      pop();
      check($sformatf("wrap8_%0d", i), data_out, 32'(8'hA0 + 8'(i)));
    end
    check("wrap8_empty", empty, 1);

    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    for (int i = 0; i < 4; i++) exp_seq[i] = 8'hB0 + 8'(i);
    for (int i = 4; i < 10; i++) exp_seq[i] = 8'hC0 + 8'(i - 4);
    for (int i = 0; i < 10; i++) begin
      both(8'hC0 + 8'(i));
      check($sformatf("rw_dout_%0d", i), data_out, 32'(exp_seq[i]));
      check($sformatf("rw_flags_%0d", i), {full, empty}, 2'b00);
    end
    for (int i = 6; i < 10; i++) begin
      pop();
      check($sformatf("rw_tail_%0d", i), data_out, 32'(8'hC0 + 8'(i)));
    end
    check("rw_tail_empty", empty, 1);

    for (int i = 0; i < 8; i++) push(8'hD0 + 8'(i));
    both(8'hEE);
    check("full_rw_dout", data_out, 8'hD0);
    check("full_rw_full", full, 0);
    for (int i = 1; i < 8; i++) begin
      pop();
      check($sformatf("full_rw_drain_%0d", i), data_out, 32'(8'hD0 + 8'(i)));
    end
    check("full_rw_empty", empty, 1);

    both(8'h55);
    check("empty_rw_dout", data_out, 8'hD7);
    check("empty_rw_empty", empty, 0);
    pop();
    check("empty_rw_read", data_out, 8'h55);
    check("empty_rw_empty2", empty, 1);

    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    rst = 1'b1; wr_en = 1'b1; data_in = 8'h77;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_dout", data_out, 8'h00);
    pop();
    check("mid_rst_read", data_out, 8'h00);
    check("mid_rst_read_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
